// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
//   req_id_e         : requester identity (REQ_CPU = 0, REQ_LOADER = 1)
//   tag_t            : in-flight response tag (valid bit + requester id)
//   MAX_READ_LATENCY : deepest supported RAM read latency
package mem_port_arbiter_pkg;

  typedef enum logic {
    REQ_CPU    = 1'b0,
    REQ_LOADER = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } tag_t;

  localparam int MAX_READ_LATENCY = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// One requester's request/response bundle.
//   master : requester side (drives req_valid/addr/wdata/wbe)
//   slave  : arbiter side (drives req_ready, resp_valid, resp_rdata)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready never depends on itself and is only
// high while req_valid is high. The requester keeps valid/addr/wdata/wbe
// stable until the transfer; dropping valid early just gives up the grant.
// Each transfer (read or write) yields exactly one resp_valid pulse, in
// acceptance order; resp_rdata is meaningful only with resp_valid.
interface mem_port_arbiter_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 15
);
  logic                  req_valid;
  logic                  req_ready;
  logic [AWIDTH-1:0]     req_addr;
  logic [DWIDTH-1:0]     req_wdata;
  logic [DWIDTH/8-1:0]   req_wbe;
  logic                  resp_valid;
  logic [DWIDTH-1:0]     resp_rdata;

  modport master (
    output req_valid, req_addr, req_wdata, req_wbe,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wbe,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_resp_tag_pipe.sv
// resp_tag_pipe: READ_LATENCY-deep shift register carrying the tag of each
// accepted request so its response strobe lines up with RAM read data.
//   clk, rst : clock, synchronous active-high reset (clears all stages)
//   tag_in   : tag of the request accepted this cycle (valid=0 if none)
//   tag_out  : tag accepted READ_LATENCY cycles ago
module resp_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < READ_LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[READ_LATENCY-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous RAM port between the CPU data
// port (r0) and the UART loader (r1), one acceptance per cycle.
//   clk, rst      : clock, synchronous active-high reset
//   r0, r1        : requester bundles (mem_port_arbiter_if.slave)
//   mem_en/we/addr/wdata : RAM command, driven in the acceptance cycle
//   mem_rdata     : RAM read data, READ_LATENCY cycles after mem_en
// Build option MEM_ARB_RR_EN: round-robin on contention. Without it, r0 has
// fixed priority and r1 is forced through after STARVE_LIMIT lost cycles.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 15,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   r0,
  mem_port_arbiter_if.slave   r1,
  output logic                mem_en,
  output logic [DWIDTH/8-1:0] mem_we,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic [DWIDTH-1:0]   mem_wdata,
  input  logic [DWIDTH-1:0]   mem_rdata
);

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_lat
    $error("READ_LATENCY out of range");
  end

  logic grant0;
  logic grant1;
  logic prefer1;  // r1 wins if both requesters are valid

`ifdef MEM_ARB_RR_EN
  req_id_e last_grant;

  assign prefer1 = (last_grant == REQ_CPU);

  always_ff @(posedge clk) begin
    if (rst)         last_grant <= REQ_LOADER;
    else if (grant1) last_grant <= REQ_LOADER;
    else if (grant0) last_grant <= REQ_CPU;
  end
`else
  localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);
  logic [7:0] starve_cnt;

  // Counter never passes the limit: reaching it forces the r1 grant,
  // which clears it.
  assign prefer1 = (starve_cnt == STARVE_LIM8);

  always_ff @(posedge clk) begin
    if (rst)                            starve_cnt <= '0;
    else if (r1.req_valid && !grant1)   starve_cnt <= starve_cnt + 8'd1;
    else                                starve_cnt <= '0;
  end
`endif

  always_comb begin
    grant1 = !rst && r1.req_valid && (!r0.req_valid || prefer1);
    grant0 = !rst && r0.req_valid && !grant1;
  end

  assign r0.req_ready = grant0;
  assign r1.req_ready = grant1;

  always_comb begin
    mem_en    = grant0 || grant1;
    mem_we    = '0;
    mem_addr  = r0.req_addr;
    mem_wdata = r0.req_wdata;
    if (grant1) begin
      mem_we    = r1.req_wbe;
      mem_addr  = r1.req_addr;
      mem_wdata = r1.req_wdata;
    end else if (grant0) begin
      mem_we    = r0.req_wbe;
    end
  end

  tag_t tag_in;
  tag_t tag_out;

  always_comb begin
    tag_in.valid = mem_en;
    tag_in.id    = grant1 ? REQ_LOADER : REQ_CPU;
  end

  resp_tag_pipe #(.READ_LATENCY(READ_LATENCY)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Gated by rst so nothing leaks out during the first reset cycle, before
  // the synchronous clear of the pipe has taken effect.
  logic resp0;
  logic resp1;
  assign resp0 = !rst && tag_out.valid && (tag_out.id == REQ_CPU);
  assign resp1 = !rst && tag_out.valid && (tag_out.id == REQ_LOADER);

  assign r0.resp_valid = resp0;
  assign r1.resp_valid = resp1;
  assign r0.resp_rdata = resp0 ? mem_rdata : '0;
  assign r1.resp_rdata = resp1 ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Main instance: READ_LATENCY=1,
// STARVE_LIMIT=3. Second instance: READ_LATENCY=2 for latency and
// reset-while-in-flight checks. Honors MEM_ARB_RR_EN for the contention step.
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 15;

  logic clk = 1'b0;
  logic rst;
  logic rst_b;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) r0_if ();
  mem_port_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) r1_if ();
  mem_port_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) r0b_if ();
  mem_port_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) r1b_if ();

  logic          mem_en,    mem_en_b;
  logic [3:0]    mem_we,    mem_we_b;
  logic [AW-1:0] mem_addr,  mem_addr_b;
  logic [DW-1:0] mem_wdata, mem_wdata_b;
  logic [DW-1:0] mem_rdata, mem_rdata_b;

  mem_port_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .READ_LATENCY(1), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .r0(r0_if), .r1(r1_if),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .READ_LATENCY(2), .STARVE_LIMIT(3)) dut_b (
    .clk(clk), .rst(rst_b), .r0(r0b_if), .r1(r1b_if),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  // RAM models, preloaded while in reset
  logic [31:0] ram   [0:1023];
  logic [31:0] ram_b [0:1023];
  logic [31:0] rd_b1;

  always @(posedge clk) begin
    if (rst) begin
      ram[16] <= 32'hDEADBEEF;
      ram[32] <= 32'hFFFFFFFF;
    end else if (mem_en) begin
      mem_rdata <= ram[mem_addr[9:0]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (rst_b) ram_b[16] <= 32'hDEADBEEF;
    else if (mem_en_b)
      for (int b = 0; b < 4; b++)
        if (mem_we_b[b]) ram_b[mem_addr_b[9:0]][8*b +: 8] <= mem_wdata_b[8*b +: 8];
    rd_b1       <= ram_b[mem_addr_b[9:0]];
    mem_rdata_b <= rd_b1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int who, input logic v, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [3:0] be);
    case (who)
      0: begin r0_if.req_valid = v; r0_if.req_addr = a; r0_if.req_wdata = d; r0_if.req_wbe = be; end
      1: begin r1_if.req_valid = v; r1_if.req_addr = a; r1_if.req_wdata = d; r1_if.req_wbe = be; end
      default: begin r0b_if.req_valid = v; r0b_if.req_addr = a; r0b_if.req_wdata = d; r0b_if.req_wbe = be; end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] g;

  initial begin
    rst = 1'b1;
    rst_b = 1'b1;
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    drive(2, 1'b0, '0, '0, '0);
    r1b_if.req_valid = 1'b0; r1b_if.req_addr = '0; r1b_if.req_wdata = '0; r1b_if.req_wbe = '0;

    // Reset: a valid request must not be accepted while rst is high
    step(); step();
    drive(0, 1'b1, 15'h0010, '0, 4'h0);
    @(negedge clk);
    check("rst_r0_ready", {31'd0, r0_if.req_ready}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_we", {28'd0, mem_we}, 32'd0);
    check("rst_r0_resp_valid", {31'd0, r0_if.resp_valid}, 32'd0);
    check("rst_r1_rdata", r1_if.resp_rdata, 32'd0);

    // Single read, first cycle out of reset
    step();
    rst = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("rd_r0_ready", {31'd0, r0_if.req_ready}, 32'd1);
    check("rd_r1_ready", {31'd0, r1_if.req_ready}, 32'd0);
    check("rd_mem_en", {31'd0, mem_en}, 32'd1);
    check("rd_mem_we", {28'd0, mem_we}, 32'd0);
    check("rd_mem_addr", {17'd0, mem_addr}, 32'h10);
    step();
    drive(0, 1'b0, '0, '0, 4'h0);
    @(negedge clk);
    check("rd_r0_resp_valid", {31'd0, r0_if.resp_valid}, 32'd1);
    check("rd_r0_rdata", r0_if.resp_rdata, 32'hDEADBEEF);
    check("rd_r1_resp_valid", {31'd0, r1_if.resp_valid}, 32'd0);
    check("rd_r1_rdata", r1_if.resp_rdata, 32'd0);
    check("idle_mem_en", {31'd0, mem_en}, 32'd0);
    step();
    @(negedge clk);
    check("rd_r0_resp_done", {31'd0, r0_if.resp_valid}, 32'd0);

    // r1 writes, r0 reads back
    drive(1, 1'b1, 15'h0100, 32'h12345678, 4'hF);
    @(negedge clk);
    check("wr_r1_ready", {31'd0, r1_if.req_ready}, 32'd1);
    check("wr_mem_we", {28'd0, mem_we}, 32'hF);
    check("wr_mem_wdata", mem_wdata, 32'h12345678);
    step();
    drive(1, 1'b0, '0, '0, 4'h0);
    drive(0, 1'b1, 15'h0100, '0, 4'h0);
    @(negedge clk);
    check("wr_r1_resp_valid", {31'd0, r1_if.resp_valid}, 32'd1);
    check("wr_r0_resp_valid", {31'd0, r0_if.resp_valid}, 32'd0);
    check("wrrd_r0_ready", {31'd0, r0_if.req_ready}, 32'd1);
    step();
    drive(0, 1'b0, '0, '0, 4'h0);
    @(negedge clk);
    check("wrrd_r0_resp_valid", {31'd0, r0_if.resp_valid}, 32'd1);
    check("wrrd_r0_rdata", r0_if.resp_rdata, 32'h12345678);

    // Partial write then back-to-back read from r0
    step();
    drive(0, 1'b1, 15'h0020, 32'hAAAABBBB, 4'h3);
    @(negedge clk);
    check("pw_mem_we", {28'd0, mem_we}, 32'h3);
    step();
    drive(0, 1'b1, 15'h0020, '0, 4'h0);
    @(negedge clk);
    check("pw_wr_resp_valid", {31'd0, r0_if.resp_valid}, 32'd1);
    check("pw_rd_ready", {31'd0, r0_if.req_ready}, 32'd1);
    step();
    drive(0, 1'b0, '0, '0, 4'h0);
    @(negedge clk);
    check("pw_rd_resp_valid", {31'd0, r0_if.resp_valid}, 32'd1);
    check("pw_rd_rdata", r0_if.resp_rdata, 32'hFFFFBBBB);

    // Contention right after a reset; bit i of g = r1 granted in cycle i
`ifdef MEM_ARB_RR_EN
    g = 5'b01010;
`else
    g = 5'b01000;
`endif
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 1'b1, 15'h0010, '0, 4'h0);
    drive(1, 1'b1, 15'h0100, '0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 5) begin
        check($sformatf("ct_r1_ready_%0d", i), {31'd0, r1_if.req_ready}, {31'd0, g[i]});
        check($sformatf("ct_r0_ready_%0d", i), {31'd0, r0_if.req_ready}, {31'd0, !g[i]});
      end
      if (i > 0) begin
        check($sformatf("ct_r1_resp_%0d", i), {31'd0, r1_if.resp_valid}, {31'd0, g[i-1]});
        check($sformatf("ct_r0_resp_%0d", i), {31'd0, r0_if.resp_valid}, {31'd0, !g[i-1]});
        if (g[i-1]) check($sformatf("ct_r1_rdata_%0d", i), r1_if.resp_rdata, 32'h12345678);
        else        check($sformatf("ct_r0_rdata_%0d", i), r0_if.resp_rdata, 32'hDEADBEEF);
      end
      step();
      if (i == 4) begin
        drive(0, 1'b0, '0, '0, 4'h0);
        drive(1, 1'b0, '0, '0, 4'h0);
      end
    end

    // Latency-2 instance: normal read returns two cycles after acceptance
    drive(2, 1'b1, 15'h0010, '0, 4'h0);
    @(negedge clk);
    check("l2_ready", {31'd0, r0b_if.req_ready}, 32'd1);
    step();
    drive(2, 1'b0, '0, '0, 4'h0);
    @(negedge clk);
    check("l2_resp_early", {31'd0, r0b_if.resp_valid}, 32'd0);
    step();
    @(negedge clk);
    check("l2_resp_valid", {31'd0, r0b_if.resp_valid}, 32'd1);
    check("l2_rdata", r0b_if.resp_rdata, 32'hDEADBEEF);
    step();
    @(negedge clk);
    check("l2_resp_done", {31'd0, r0b_if.resp_valid}, 32'd0);

    // Latency-2 instance: reset the cycle after acceptance drops the response
    drive(2, 1'b1, 15'h0010, '0, 4'h0);
    @(negedge clk);
    check("rf_ready", {31'd0, r0b_if.req_ready}, 32'd1);
    step();
    drive(2, 1'b0, '0, '0, 4'h0);
    rst_b = 1'b1;
    @(negedge clk);
    check("rf_resp_in_rst", {31'd0, r0b_if.resp_valid}, 32'd0);
    step();
    rst_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rf_resp_after_%0d", i), {31'd0, r0b_if.resp_valid}, 32'd0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter AWIDTH, default 15, word-address width.
REQ-003 SHALL have parameter READ_LATENCY, default 1, memory read latency in cycles (1..4).
REQ-004 SHALL have parameter STARVE_LIMIT, default 8, maximum consecutive lost cycles for requester 1 under fixed priority (1..255).
REQ-005 SHALL have clk  input  1  clock; all logic on the rising edge.
REQ-006 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have rN_req_valid  input  1  request from requester N (N = 0 CPU data port, N = 1 UART loader).
REQ-008 SHALL have rN_req_ready  output  1  request accepted this cycle.
REQ-009 SHALL have rN_req_addr  input  AWIDTH  word address.
REQ-010 SHALL have rN_req_wdata  input  DWIDTH  write data.
REQ-011 SHALL have rN_req_wbe  input  DWIDTH/8  byte write enables; all-zero means read.
REQ-012 SHALL have rN_resp_valid  output  1  completion strobe for an accepted request.
REQ-013 SHALL have rN_resp_rdata  output  DWIDTH  read data, valid with rN_resp_valid.
REQ-014 SHALL have mem_en, mem_we[DWIDTH/8], mem_addr[AWIDTH], mem_wdata[DWIDTH]  outputs  single synchronous RAM port.
REQ-015 SHALL have mem_rdata  input  DWIDTH  RAM read data, READ_LATENCY cycles after mem_en.

Function
REQ-016 SHALL accept at most one request per cycle; rN_req_ready SHALL be combinational from valids and arbitration state, asserted only for the granted requester and only when its rN_req_valid is high.
REQ-017 SHALL drive mem_en/mem_we/mem_addr/mem_wdata combinationally from the granted request in the acceptance cycle; mem_en=0 and mem_we=0 when nothing is accepted.
REQ-018 SHALL pulse rN_resp_valid exactly READ_LATENCY cycles after acceptance, for both reads and writes, using a READ_LATENCY-deep tag shift register (valid bit + requester id).
REQ-019 SHALL drive rN_resp_rdata = mem_rdata when that requester's response is valid and zero otherwise.
REQ-020 SHALL sustain back-to-back acceptance (one per cycle) with responses returned in acceptance order.
REQ-021 Requesters SHALL hold valid/addr/data stable until ready; the arbiter need not check this, and a dropped valid merely forfeits the grant.
REQ-022 When only one requester is valid it SHALL be granted in that cycle regardless of arbitration mode.
REQ-023 Write followed by read of the same address from either requester SHALL return the written data (ordering preserved by the single port).

Reset
REQ-024 During rst all ready, resp_valid, mem_en and mem_we outputs SHALL be 0; rdata outputs 0.
REQ-025 Reset SHALL clear all tag pipeline entries (in-flight responses are dropped, never delivered), set the round-robin last-grant pointer to 1, and clear the starvation counter.
REQ-026 First cycle after rst deasserts SHALL arbitrate normally.

Configuration
REQ-027 With MEM_ARB_RR_EN defined: round-robin — on contention grant the requester other than the last granted; pointer updates on every acceptance.
REQ-028 Without MEM_ARB_RR_EN: fixed priority to requester 0; an 8-bit counter increments each cycle requester 1 is valid but not granted, resets on requester-1 grant or requester-1 invalid; when counter == STARVE_LIMIT requester 1 SHALL be granted that cycle over requester 0.

Structure
REQ-029 Shared package SHALL hold requester-id enum (REQ_CPU=0, REQ_LOADER=1), tag struct (valid, id) and the maximum READ_LATENCY constant.
REQ-030 Tag shift register SHALL be a sub-module resp_tag_pipe parameterized by READ_LATENCY; arbitration logic stays in mem_port_arbiter.

Verification
REQ-031 Single read: r0 read addr 0x0010, RAM holds 0xDEADBEEF -> r0_req_ready same cycle, r0_resp_valid 1 cycle later with 0xDEADBEEF, r1 outputs idle.
REQ-032 Contention with MEM_ARB_RR_EN: both valid continuously for 4 cycles after reset -> grants r0, r1, r0, r1; responses in that order.
REQ-033 Starvation without macro, STARVE_LIMIT=3: both valid continuously -> r0 granted cycles 0-2, r1 granted cycle 3, r0 again cycle 4.
REQ-034 Write then read: r1 writes 0x12345678 wbe=0xF to 0x0100, next cycle r0 reads 0x0100 -> r0 rdata 0x12345678.
REQ-035 Reset mid-flight, READ_LATENCY=2: accept r0 read, assert rst next cycle -> no r0_resp_valid ever appears for that request.
REQ-036 Partial write: wbe=0x3 data 0xAAAABBBB over 0xFFFFFFFF -> subsequent read returns 0xFFFFBBBB.
